// File: rtl/vic_pkg.sv
// Shared types and default sizing for the vectored interrupt controller.
package vic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } vic_state_e;

  localparam int VIC_NUM_IRQ    = 4;
  localparam int VIC_ADDR_WIDTH = 20;
  localparam int VIC_PRIO_WIDTH = 2;
  localparam int VIC_ID_WIDTH   = 2;

endpackage

// File: rtl/vic_priority_arbiter.sv
// Combinational arbiter: highest priority among eligible channels wins,
// ties go to the lowest channel index.
module vic_priority_arbiter #(
  parameter int NUM_IRQ    = 4,
  parameter int PRIO_WIDTH = 2,
  parameter int ID_WIDTH   = 2
) (
  input  logic [NUM_IRQ-1:0]            eligible_i,
  input  logic [NUM_IRQ*PRIO_WIDTH-1:0] prio_i,
  output logic                          valid_o,
  output logic [ID_WIDTH-1:0]           win_id_o
);

  logic [PRIO_WIDTH-1:0] best;

  // Ascending scan with strict '>' so an equal priority never displaces a lower index.
  always_comb begin
    valid_o  = 1'b0;
    win_id_o = '0;
    best     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible_i[i] && (!valid_o || (prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > best))) begin
        valid_o  = 1'b1;
        best     = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
        win_id_o = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/vectored_interrupt_controller.sv
// N-channel vectored interrupt controller: edge capture into pending bits,
// mask/priority arbitration, and a req/ack/done handshake toward the PC.
module vectored_interrupt_controller
  import vic_pkg::*;
#(
  parameter int NUM_IRQ    = VIC_NUM_IRQ,
  parameter int ADDR_WIDTH = VIC_ADDR_WIDTH,
  parameter int PRIO_WIDTH = VIC_PRIO_WIDTH,
  parameter int ID_WIDTH   = VIC_ID_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic                  interrupt_enable,
  input  logic                  interrupt_disable,
  input  logic                  cfg_we,
  input  logic [ID_WIDTH-1:0]   cfg_sel,
  input  logic [ADDR_WIDTH-1:0] cfg_vector,
  input  logic [PRIO_WIDTH-1:0] cfg_prio,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    mask_in,
  input  logic                  irq_ack,
  input  logic                  irq_done,
  output logic                  irq_req,
  output logic [ADDR_WIDTH-1:0] irq_vector,
  output logic [ID_WIDTH-1:0]   irq_id,
  output logic                  busy,
  output logic [NUM_IRQ-1:0]    pending
);

  vic_state_e                  state_q, state_d;
  logic [NUM_IRQ-1:0]          irq_q;
  logic [NUM_IRQ-1:0]          pending_q, pending_d;
  logic [NUM_IRQ-1:0]          mask_q, mask_d;
  logic                        gen_q, gen_d;
  logic [ADDR_WIDTH-1:0]       vec_q [NUM_IRQ];
  logic [PRIO_WIDTH-1:0]       prio_q [NUM_IRQ];
  logic [ID_WIDTH-1:0]         id_q, id_d;
  logic [ADDR_WIDTH-1:0]       vector_q, vector_d;
  logic [NUM_IRQ-1:0]          rise;
  logic [NUM_IRQ-1:0]          eligible;
  logic [NUM_IRQ-1:0]          ack_clr;
  logic [NUM_IRQ*PRIO_WIDTH-1:0] prio_flat;
  logic                        win_valid;
  logic [ID_WIDTH-1:0]         win_id;

  assign rise     = irq_in & ~irq_q;
  assign eligible = gen_q ? (pending_q & ~mask_q) : '0;

  // Next global enable and mask; disable wins over enable.
  always_comb begin
    gen_d = gen_q;
    if (interrupt_enable)  gen_d = 1'b1;
    if (interrupt_disable) gen_d = 1'b0;
    mask_d = mask_we ? mask_in : mask_q;
  end

  // Flatten the priority table for the arbiter port.
  always_comb begin
    prio_flat = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      prio_flat[i*PRIO_WIDTH +: PRIO_WIDTH] = prio_q[i];
    end
  end

  vic_priority_arbiter #(
    .NUM_IRQ   (NUM_IRQ),
    .PRIO_WIDTH(PRIO_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) u_arb (
    .eligible_i(eligible),
    .prio_i    (prio_flat),
    .valid_o   (win_valid),
    .win_id_o  (win_id)
  );

  // Handshake FSM; withdrawal looks at next-cycle enable/mask so REQ drops right after the change.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    vector_d = vector_q;
    ack_clr  = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = REQ;
          id_d     = win_id;
          vector_d = vec_q[win_id];
        end
      end
      REQ: begin
        if (irq_ack) begin
          ack_clr[id_q] = 1'b1;
          state_d       = SERVICE;
        end else if (!gen_d || mask_d[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge in the ack cycle keeps the bit set.
    pending_d = (pending_q & ~ack_clr) | rise;
  end

  // Control state, pending bits and grant latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      gen_q     <= 1'b0;
      id_q      <= '0;
      vector_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      gen_q     <= gen_d;
      id_q      <= id_d;
      vector_q  <= vector_d;
    end
  end

  // Per-channel vector and priority table.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        vec_q[i]  <= '0;
        prio_q[i] <= '0;
      end
    end else if (cfg_we) begin
      vec_q[cfg_sel]  <= cfg_vector;
      prio_q[cfg_sel] <= cfg_prio;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign busy       = (state_q == SERVICE);
  assign irq_id     = id_q;
  assign irq_vector = vector_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Directed self-checking bench for vectored_interrupt_controller.
module tb_vectored_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        interrupt_enable = 1'b0;
  logic        interrupt_disable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [19:0] cfg_vector = '0;
  logic [1:0]  cfg_prio = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_in = '0;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic        irq_req;
  logic [19:0] irq_vector;
  logic [1:0]  irq_id;
  logic        busy;
  logic [3:0]  pending;

  int compared = 0;
  int mismatched = 0;

  vectored_interrupt_controller #(
    .NUM_IRQ(4), .ADDR_WIDTH(20), .PRIO_WIDTH(2), .ID_WIDTH(2)
  ) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in),
    .interrupt_enable(interrupt_enable), .interrupt_disable(interrupt_disable),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_vector(cfg_vector), .cfg_prio(cfg_prio),
    .mask_we(mask_we), .mask_in(mask_in), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_req(irq_req), .irq_vector(irq_vector), .irq_id(irq_id), .busy(busy),
    .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [19:0] vec, input logic [1:0] pr);
    cfg_we = 1'b1; cfg_sel = sel; cfg_vector = vec; cfg_prio = pr;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic enable();
    interrupt_enable = 1'b1;
    tick();
    interrupt_enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_req",     32'(irq_req),    32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_pending", 32'(pending),    32'd0);
    chk("rst_id",      32'(irq_id),     32'd0);
    chk("rst_vector",  32'(irq_vector), 32'd0);

    // Basic grant
    cfg(2'd2, 20'h00400, 2'd1);
    set_mask(4'b0000);
    enable();
    pulse_irq(4'b0100);
    chk("basic_pend",   32'(pending), 32'h4);
    chk("basic_req0",   32'(irq_req), 32'd0);
    tick();
    chk("basic_req",    32'(irq_req),    32'd1);
    chk("basic_id",     32'(irq_id),     32'd2);
    chk("basic_vec",    32'(irq_vector), 32'h00400);
    do_ack();
    chk("basic_ackreq", 32'(irq_req), 32'd0);
    chk("basic_busy",   32'(busy),    32'd1);
    chk("basic_clr",    32'(pending), 32'h0);
    do_done();
    chk("basic_idle",   32'(busy),    32'd0);
    tick();
    chk("basic_noreq",  32'(irq_req), 32'd0);

    // Priority and tie
    cfg(2'd1, 20'h00100, 2'd3);
    cfg(2'd3, 20'h00300, 2'd3);
    cfg(2'd0, 20'h00010, 2'd2);
    pulse_irq(4'b1011);
    chk("prio_pend", 32'(pending), 32'hb);
    tick();
    chk("prio_id1",  32'(irq_id),     32'd1);
    chk("prio_vec1", 32'(irq_vector), 32'h00100);
    do_ack();
    chk("prio_pend2", 32'(pending), 32'h9);
    do_done();
    tick();
    chk("prio_req3", 32'(irq_req),    32'd1);
    chk("prio_id3",  32'(irq_id),     32'd3);
    chk("prio_vec3", 32'(irq_vector), 32'h00300);
    do_ack();
    do_done();
    tick();
    chk("prio_id0",  32'(irq_id),     32'd0);
    chk("prio_vec0", 32'(irq_vector), 32'h00010);
    do_ack();
    do_done();

    // Masking
    set_mask(4'b0010);
    pulse_irq(4'b0010);
    chk("mask_pend", 32'(pending), 32'h2);
    tick();
    chk("mask_noreq1", 32'(irq_req), 32'd0);
    tick();
    chk("mask_noreq2", 32'(irq_req), 32'd0);
    set_mask(4'b0000);
    chk("mask_unm0", 32'(irq_req), 32'd0);
    tick();
    chk("mask_req", 32'(irq_req), 32'd1);
    chk("mask_id",  32'(irq_id),  32'd1);
    do_ack();
    do_done();

    // Withdrawal by global disable
    pulse_irq(4'b0100);
    tick();
    chk("wd_req", 32'(irq_req), 32'd1);
    interrupt_disable = 1'b1;
    tick();
    interrupt_disable = 1'b0;
    chk("wd_drop", 32'(irq_req), 32'd0);
    chk("wd_pend", 32'(pending), 32'h4);
    tick();
    chk("wd_stay", 32'(irq_req), 32'd0);
    enable();
    chk("wd_en0", 32'(irq_req), 32'd0);
    tick();
    chk("wd_regrant", 32'(irq_req), 32'd1);
    chk("wd_id",      32'(irq_id),  32'd2);
    do_ack();
    do_done();

    // Set wins over ack clear
    pulse_irq(4'b0001);
    tick();
    chk("sw_id", 32'(irq_id), 32'd0);
    irq_ack = 1'b1;
    irq_in  = 4'b0001;
    tick();
    irq_ack = 1'b0;
    irq_in  = '0;
    chk("sw_pend", 32'(pending), 32'h1);
    chk("sw_busy", 32'(busy),    32'd1);
    do_done();
    tick();
    chk("sw_regrant", 32'(irq_req), 32'd1);
    chk("sw_id2",     32'(irq_id),  32'd0);
    do_ack();
    chk("sw_clr", 32'(pending), 32'h0);

    // Reset while in SERVICE
    chk("rs_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_busy",    32'(busy),    32'd0);
    chk("rs_pending", 32'(pending), 32'h0);
    chk("rs_req",     32'(irq_req), 32'd0);
    enable();
    pulse_irq(4'b0001);
    tick(); tick();
    chk("rs_masked_pend", 32'(pending), 32'h1);
    chk("rs_masked_req",  32'(irq_req), 32'd0);
    set_mask(4'b0000);
    tick();
    chk("rs_req2", 32'(irq_req),    32'd1);
    chk("rs_id",   32'(irq_id),     32'd0);
    chk("rs_vec",  32'(irq_vector), 32'h00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vectored_interrupt_controller.md
Name: vectored_interrupt_controller

Overview:
Parametrised N-channel interrupt controller that generalises the processor's two fixed interrupt addresses into a programmable vector table.
- Captures rising edges on NUM_IRQ request lines into pending bits.
- Applies per-channel mask and priority, and arbitrates the highest-priority pending channel.
- Presents that channel's vector to the program counter through a req/ack handshake, then blocks further requests until the handler signals completion.
- Sits beside the program counter; the control unit drives ack/done.

Parameters:
- NUM_IRQ, 4, number of interrupt channels (2..16)
- ADDR_WIDTH, 20, width of each vector address
- PRIO_WIDTH, 2, per-channel priority width; larger value = more urgent
- ID_WIDTH, 2, channel index width; must equal ceil(log2(NUM_IRQ))

Ports:
- clock, input, 1, system clock, rising edge
- reset, input, 1, synchronous active-high reset
- irq_in, input, NUM_IRQ, level request lines, already synchronous to clock
- interrupt_enable, input, 1, pulse: set global enable
- interrupt_disable, input, 1, pulse: clear global enable (wins if both high)
- cfg_we, input, 1, write vector and priority for channel cfg_sel
- cfg_sel, input, ID_WIDTH, channel selected for the config write
- cfg_vector, input, ADDR_WIDTH, vector address to write
- cfg_prio, input, PRIO_WIDTH, priority to write
- mask_we, input, 1, load the mask register
- mask_in, input, NUM_IRQ, 1 = channel masked
- irq_ack, input, 1, processor has taken the vector
- irq_done, input, 1, handler return
- irq_req, output, 1, interrupt request to the program counter
- irq_vector, output, ADDR_WIDTH, vector of the granted channel
- irq_id, output, ID_WIDTH, index of the granted channel
- busy, output, 1, a handler is in service
- pending, output, NUM_IRQ, raw pending bits

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE; pending 0; mask all 1; global enable 0.
  - All vectors 0; all prios 0; irq_q 0.
  - irq_req 0, irq_vector 0, irq_id 0, busy 0.
- Edge capture:
  - irq_q <= irq_in every cycle; edge = irq_in & ~irq_q.
  - A set pending bit stays set until acked.
  - Masked channels still capture edges.
- Eligibility: eligible = pending & ~mask, gated by global enable.
- Arbitration (combinational): the highest prio wins; on a tie, the lowest index wins.
- FSM IDLE:
  - Go to REQ at the next edge if any channel is eligible.
  - Latch the winner's id and vector on that transition.
- FSM REQ:
  - irq_req = 1; irq_id and irq_vector stay stable while in REQ, even if a higher-priority channel arrives.
  - irq_ack: clear pending[irq_id], go to SERVICE.
  - Otherwise, if the global enable drops or the latched channel becomes masked: go to IDLE, pending is kept.
- FSM SERVICE:
  - busy = 1, irq_req = 0, no nesting.
  - irq_done: go to IDLE. Arbitration resumes the following cycle.
- Ignored inputs: irq_ack outside REQ; irq_done outside SERVICE.
- Latency: irq_in rises before edge k, so pending is set at k and irq_req is high after edge k+1 (2 cycles).
  - After irq_done at edge d, a still-eligible request reasserts irq_req after edge d+1.
- Simultaneous events:
  - A new edge on the channel being acked in the same cycle: set wins, pending stays 1.
  - cfg_we to the latched channel while in REQ: the latched vector is unchanged; the new value applies to the next grant.
  - mask_we and cfg_we take effect at the clock edge they are sampled on.
- Reset asserted in any state returns everything to reset values at that edge.

Decomposition:
- Package vic_pkg holds:
  - state typedef (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2)
  - default parameter constants
- Sub-module vic_priority_arbiter:
  - combinational; inputs eligible and the prio array.
  - outputs valid and win_id.
- Vector/prio storage, edge capture and FSM stay in the top module.

Test Plan:
- Basic grant:
  - Setup: mask=0, enable; vector[2]=20'h00400, prio[2]=1.
  - Stimulus: pulse irq_in[2].
  - Required: irq_req high 2 cycles later with id=2, vector=20'h00400; ack clears pending[2] and raises busy; done returns to IDLE.
- Priority and tie:
  - Setup: prio[1]=3, prio[3]=3, prio[0]=2; edges on 0, 1, 3 in the same cycle.
  - Required: grant order 1, 3, 0, each after done.
- Masking:
  - Stimulus: mask[1]=1, edge on 1.
  - Required: pending[1]=1, no irq_req; on unmask, irq_req follows next cycle with id=1.
- Withdrawal:
  - Stimulus: interrupt_disable pulse while in REQ.
  - Required: irq_req drops next cycle, pending bit retained; re-enable regrants the same channel.
- Set-wins collision: edge on channel 0 in the same cycle as irq_ack for id 0 -> pending[0] stays 1; regrant after done.
- Reset mid-SERVICE: assert reset -> busy=0, pending=0, mask=all 1, and all vectors read back 0 on the next grant after reconfiguration.
